// File: rtl/result_stats_pkg.sv
// ---------------------------------------------------------------------------
// result_stats_pkg
// Shared types and default sizing for the result window statistics block.
//   stats_state_e : control FSM states (IDLE, ACCUM, REPORT)
//   DEF_DATA_W    : default sample width
//   DEF_WIN_LEN   : default samples per window (power of two, >= 2)
// Optional feature macro used by the block: RESULT_STATS_MINMAX_EN
// ---------------------------------------------------------------------------
package result_stats_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } stats_state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_WIN_LEN = 16;

endpackage

// File: rtl/result_minmax_tracker.sv
// ---------------------------------------------------------------------------
// result_minmax_tracker
// Running unsigned minimum / maximum over the samples of one window.
// Only instantiated when RESULT_STATS_MINMAX_EN is defined.
// Ports:
//   clk      : clock, posedge
//   rst_n    : asynchronous active-low reset, clears min/max to 0
//   i_load   : first sample of a window, overwrite min and max
//   i_update : later sample of a window, fold into min and max
//   i_data   : sample value (unsigned)
//   o_min    : smallest sample seen since last load
//   o_max    : largest sample seen since last load
// ---------------------------------------------------------------------------
module result_minmax_tracker
    import result_stats_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_update,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_min,
    output logic [DATA_W-1:0] o_max
);

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '0;
            r_max <= '0;
        end else if (i_load) begin
            // Load unconditionally so the previous window never leaks in.
            r_min <= i_data;
            r_max <= i_data;
        end else if (i_update) begin
            if (i_data < r_min) r_min <= i_data;
            if (i_data > r_max) r_max <= i_data;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/result_window_stats.sv
// ---------------------------------------------------------------------------
// result_window_stats
// Collects WIN_LEN unsigned result samples and reports their sum, minimum
// and maximum through a valid/ready handshake, then starts the next window
// (if en is still high) or returns to idle.
// Ports:
//   clk       : clock, posedge
//   rst_n     : asynchronous active-low reset, discards any partial window
//   en        : level enable, starts/continues windowing
//   in_valid  : upstream sample valid
//   in_data   : upstream sample (unsigned, DATA_W)
//   in_ready  : high only while accumulating
//   out_valid : window statistics available (held until out_ready)
//   out_ready : downstream accepts statistics
//   out_sum   : window sum, SUM_W = DATA_W + log2(WIN_LEN), cannot overflow
//   out_min   : smallest window sample
//   out_max   : largest window sample
// Configuration: define RESULT_STATS_MINMAX_EN to build min/max tracking;
// without it out_min/out_max are tied to 0.
// ---------------------------------------------------------------------------
module result_window_stats
    import result_stats_pkg::*;
#(
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  WIN_LEN = DEF_WIN_LEN,
    localparam int SUM_W   = DATA_W + $clog2(WIN_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max
);

    localparam int               CNT_W    = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

    // Zero-extended accumulate; SUM_W is sized so a full window never wraps.
    function automatic logic [SUM_W-1:0] acc_add(
        input logic [SUM_W-1:0]  a,
        input logic [DATA_W-1:0] d
    );
        return a + SUM_W'(d);
    endfunction

    stats_state_e      r_state;
    stats_state_e      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [SUM_W-1:0]  r_sum;

    logic              w_accept;
    logic              w_first;
    logic              w_last;
    logic              w_out_hs;

    // Both handshake outputs are pure state decodes: no path from out_ready.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == REPORT);

    assign w_accept = in_valid && in_ready;
    assign w_first  = w_accept && (r_cnt == '0);
    assign w_last   = w_accept && (r_cnt == LAST_IDX);
    assign w_out_hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                // en is deliberately ignored here: a started window always completes.
                if (w_last) w_state_nxt = REPORT;
            end
            REPORT: begin
                if (w_out_hs) w_state_nxt = en ? ACCUM : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter is exactly CNT_W bits, so the WIN_LEN-th acceptance wraps it
    // to 0 on the same edge that enters REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sum register doubles as the output holding register; it only changes
    // on acceptance, which cannot happen in REPORT, so it is stable there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_first) begin
            r_sum <= SUM_W'(in_data);
        end else if (w_accept) begin
            r_sum <= acc_add(r_sum, in_data);
        end
    end

    assign out_sum = r_sum;

`ifdef RESULT_STATS_MINMAX_EN
    result_minmax_tracker #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_first),
        .i_update (w_accept && !w_first),
        .i_data   (in_data),
        .o_min    (out_min),
        .o_max    (out_max)
    );
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_result_window_stats.sv
// ---------------------------------------------------------------------------
// tb_result_window_stats
// Self-checking bench for result_window_stats with WIN_LEN=4, DATA_W=8.
// Expected min/max follow RESULT_STATS_MINMAX_EN (sample values when
// defined, 0 when not).
// ---------------------------------------------------------------------------
module tb_result_window_stats;

    localparam int DW = 8;
    localparam int WL = 4;
    localparam int SW = 10;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          en        = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] s [4];
        int         e_sum;
        int         e_min;
        int         e_max;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    result_window_stats #(
        .DATA_W  (DW),
        .WIN_LEN (WL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_min   (out_min),
        .out_max   (out_max)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mm(input int v);
`ifdef RESULT_STATS_MINMAX_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic over the window contents.
    task automatic model(input logic [7:0] s [4], output int sm, output int mn, output int mx);
        sm = 0;
        mn = 255;
        mx = 0;
        for (int i = 0; i < WL; i++) begin
            sm += int'(s[i]);
            if (int'(s[i]) < mn) mn = int'(s[i]);
            if (int'(s[i]) > mx) mx = int'(s[i]);
        end
        mn = mm(mn);
        mx = mm(mx);
    endtask

    task automatic send(input logic [7:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic collect(input string name, input int hold, input int es, input int emin, input int emax);
        int k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_sum"},   32'(out_sum),   32'(es));
        chk({name, "_min"},   32'(out_min),   32'(emin));
        chk({name, "_max"},   32'(out_max),   32'(emax));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            tick();
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_sum"},   32'(out_sum),   32'(es));
            chk({name, "_hold_max"},   32'(out_max),   32'(emax));
            chk({name, "_hold_inrdy"}, 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_win(input string name, input logic [7:0] s [4], input int gaps_max,
                           input int hold, input int es, input int emin, input int emax);
        for (int i = 0; i < WL; i++) begin
            repeat ($urandom_range(gaps_max, 0)) tick();
            send(s[i]);
        end
        chk({name, "_latency"}, 32'(out_valid), 32'd1);
        collect(name, hold, es, emin, emax);
    endtask

    initial begin
        logic [7:0] rs [4];
        int sm, mn, mx;

        vecs[0].s = '{8'd1, 8'd2, 8'd3, 8'd4};
        vecs[0].e_sum = 10;   vecs[0].e_min = mm(1);   vecs[0].e_max = mm(4);
        vecs[1].s = '{8'd255, 8'd255, 8'd255, 8'd255};
        vecs[1].e_sum = 1020; vecs[1].e_min = mm(255); vecs[1].e_max = mm(255);
        vecs[2].s = '{8'd0, 8'd7, 8'd0, 8'd9};
        vecs[2].e_sum = 16;   vecs[2].e_min = mm(0);   vecs[2].e_max = mm(9);
        vecs[3].s = '{8'd3, 8'd9, 8'd1, 8'd7};
        vecs[3].e_sum = 20;   vecs[3].e_min = mm(1);   vecs[3].e_max = mm(9);

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_min",   32'(out_min),   32'd0);
        chk("rst_out_max",   32'(out_max),   32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // First window with out_ready held high throughout (ignored outside REPORT)
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < WL; i++) begin
            send(vecs[0].s[i]);
            if (i < WL - 1) chk("v0_no_early_valid", 32'(out_valid), 32'd0);
        end
        chk("v0_latency", 32'(out_valid), 32'd1);
        collect("v0", 0, vecs[0].e_sum, vecs[0].e_min, vecs[0].e_max);

        // Remaining table vectors; vector 1 stalls downstream for 5 cycles
        for (int v = 1; v < 4; v++) begin
            run_win($sformatf("v%0d", v), vecs[v].s, (v == 1) ? 0 : 2,
                    (v == 1) ? 5 : 0, vecs[v].e_sum, vecs[v].e_min, vecs[v].e_max);
        end

        // en dropped mid-window: window completes, reports, then idles
        send(8'd10);
        send(8'd20);
        en = 1'b0;
        send(8'd30);
        send(8'd40);
        chk("endrop_latency", 32'(out_valid), 32'd1);
        collect("endrop", 1, 100, mm(10), mm(40));
        chk("endrop_idle_inrdy", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("endrop_idle_inrdy2", 32'(in_ready),  32'd0);
        chk("endrop_idle_valid",  32'(out_valid), 32'd0);

        // Reset mid-window discards the partial window
        en = 1'b1;
        send(8'd5);
        send(8'd6);
        chk("pre_rst_sum", 32'(out_sum), 32'd11);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sum",   32'(out_sum),   32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_inrdy", 32'(in_ready),  32'd0);
        chk("mid_rst_min",   32'(out_min),   32'd0);
        chk("mid_rst_max",   32'(out_max),   32'd0);
        tick();
        rst_n = 1'b1;
        rs = '{8'd1, 8'd1, 8'd1, 8'd1};
        run_win("post_rst", rs, 1, 0, 4, mm(1), mm(1));

        // Randomized windows against the reference model
        for (int w = 0; w < 10; w++) begin
            for (int i = 0; i < WL; i++) begin
                case ($urandom_range(3, 0))
                    0:       rs[i] = 8'd0;
                    1:       rs[i] = 8'd255;
                    default: rs[i] = 8'($urandom);
                endcase
            end
            model(rs, sm, mn, mx);
            run_win($sformatf("rand%0d", w), rs, 2, $urandom_range(3, 0), sm, mn, mx);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_window_stats.md
RESULT_WINDOW_STATS -- requirements
Module: result_window_stats

Interface
REQ-001 Parameter DATA_W, default 8: width of each incoming result sample.
REQ-002 Parameter WIN_LEN, default 16: samples per window; SHALL be a power of two, at least 2.
REQ-003 Derived SUM_W SHALL equal DATA_W + $clog2(WIN_LEN).
REQ-004 Port clk, input, 1: single clock; all state on posedge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port en, input, 1: level enable; starts and continues windowing.
REQ-007 Port in_valid, input, 1: upstream result sample valid.
REQ-008 Port in_data, input, DATA_W: upstream result sample, unsigned.
REQ-009 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-010 Port out_valid, output, 1: window statistics available.
REQ-011 Port out_ready, input, 1: downstream accepts statistics.
REQ-012 Port out_sum, output, SUM_W: sum of the window's samples.
REQ-013 Port out_min and port out_max, outputs, DATA_W each: smallest and largest window sample.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and REPORT.
REQ-015 Transitions: IDLE->ACCUM when en=1; ACCUM->REPORT on acceptance of the WIN_LEN-th sample.
REQ-016 From REPORT, on out_valid&&out_ready, the FSM SHALL go to ACCUM if en=1, else to IDLE.
REQ-017 in_ready SHALL be 1 only in ACCUM, decoded from state, with no combinational path from out_ready.
REQ-018 A sample SHALL be accepted only when in_valid&&in_ready; the sample counter increments by 1 per acceptance.
REQ-019 The sample counter SHALL wrap to 0 on entry to REPORT.
REQ-020 The first sample of a window SHALL load sum, min and max directly, without combining with prior values.
REQ-021 Each later sample SHALL add to the sum (zero-extended, never wraps) and update min/max with unsigned compare.
REQ-022 out_valid SHALL assert the cycle after the last sample is accepted, giving 1-cycle latency.
REQ-023 out_sum, out_min and out_max SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL drop the cycle after the handshake completes.
REQ-025 en deasserted during ACCUM SHALL NOT abort the window: it completes, reports, then goes to IDLE.
REQ-026 in_valid gaps SHALL only stall accumulation; no timeout.
REQ-027 out_ready=1 outside REPORT SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL force IDLE and zero the counter, out_valid, out_sum, out_min and out_max; in_ready is then 0.
REQ-029 Reset mid-window SHALL discard the partial window; the next window starts at sample count 0.

Configuration
REQ-030 Macro RESULT_STATS_MINMAX_EN defined: min/max tracking SHALL be compiled in as specified.
REQ-031 RESULT_STATS_MINMAX_EN undefined: out_min and out_max SHALL be constant 0, no compare logic, sum/handshake unchanged.

Structure
REQ-032 Package result_stats_pkg SHALL hold the state enum stats_state_e and the default DATA_W/WIN_LEN constants.
REQ-033 Sub-module result_minmax_tracker SHALL hold min/max registers with load/update inputs; it is instantiated only under the macro.

Verification (WIN_LEN=4, DATA_W=8, macro defined unless noted)
REQ-034 Samples 1,2,3,4, en=1, out_ready=1 -> out_valid one cycle after 4th; sum=10, min=1, max=4.
REQ-035 out_ready held 0 for 5 cycles in REPORT -> outputs stable, in_ready=0, next window's samples accepted after handshake.
REQ-036 Samples 255,255,255,255 -> sum=1020 (10-bit), max=255; samples 0,7,0,9 -> min=0.
REQ-037 en dropped after 2nd sample -> window completes with 4 samples, reports, FSM in IDLE, in_ready=0.
REQ-038 rst_n pulsed low after 2 samples (5,6) -> all outputs 0; next window 1,1,1,1 -> sum=4.
REQ-039 Macro undefined, samples 3,9,1,7 -> sum=20, out_min=0, out_max=0.
